// File: rtl/abr_masked_b2a_conv.sv
// First-order masked Boolean-to-arithmetic share converter using Goubin's method.
// Latency: 4 clocks from accept to valid_o, then the result is held in DONE.
// Backpressure: result held stable while !ready_i; ready_o is high only in IDLE.
module abr_masked_b2a_conv #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             zeroize,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [1:0]       x_i [WIDTH-1:0],
    input  logic [WIDTH-1:0] rnd_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] a0_o,
    output logic [WIDTH-1:0] a1_o
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ST1  = 3'd1,
        ST2  = 3'd2,
        ST3  = 3'd3,
        ST4  = 3'd4,
        DONE = 3'd5
    } state_t;

    state_t state;
    state_t state_nxt;

    logic clr;
    logic [WIDTH-1:0] x0;
    logic [WIDTH-1:0] x1;

    // Every intermediate is registered so no cloud of logic ever sees x0 and x1
    // together without a mask; the attributes stop retiming/merging across steps.
    (* keep = "true", dont_touch = "true" *) logic [WIDTH-1:0] xr0;
    (* keep = "true", dont_touch = "true" *) logic [WIDTH-1:0] xr1;
    (* keep = "true", dont_touch = "true" *) logic [WIDTH-1:0] g;
    (* keep = "true", dont_touch = "true" *) logic [WIDTH-1:0] g2;
    (* keep = "true", dont_touch = "true" *) logic [WIDTH-1:0] t;
    (* keep = "true", dont_touch = "true" *) logic [WIDTH-1:0] a;

    assign clr     = rst | zeroize;
    assign ready_o = (state == IDLE);

    // Unpack the per-bit share pairs into two packed share words.
    always_comb begin
        x0 = '0;
        x1 = '0;
        for (int i = 0; i < WIDTH; i++) begin
            x0[i] = x_i[i][0];
            x1[i] = x_i[i][1];
        end
    end

    // State register; rst and zeroize both abandon any conversion in flight.
    always_ff @(posedge clk) begin
        if (clr) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode: fixed four-step walk, then wait for the output handshake.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (valid_i) state_nxt = ST1;
            ST1:     state_nxt = ST2;
            ST2:     state_nxt = ST3;
            ST3:     state_nxt = ST4;
            ST4:     state_nxt = DONE;
            DONE:    if (ready_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Goubin datapath: A = [(x0^G)-G]^x0^[(x0^(G^x1))-(G^x1)] = (x0^x1) - x1.
    always_ff @(posedge clk) begin
        if (clr) begin
            xr0     <= '0;
            xr1     <= '0;
            g       <= '0;
            g2      <= '0;
            t       <= '0;
            a       <= '0;
            a0_o    <= '0;
            a1_o    <= '0;
            valid_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_i) begin
                        xr0 <= x0;
                        xr1 <= x1;
                        g   <= rnd_i;
                    end
                end
                ST1: begin
                    t  <= xr0 ^ g;
                    g2 <= g ^ xr1;
                end
                ST2: begin
                    t <= t - g;
                    a <= xr0 ^ g2;
                end
                ST3: begin
                    t <= t ^ xr0;
                    a <= a - g2;
                end
                ST4: begin
                    a0_o    <= a ^ t;
                    a1_o    <= xr1;
                    valid_o <= 1'b1;
                end
                DONE: begin
                    // Scrub shares and intermediates once the result is taken.
                    if (ready_i) begin
                        xr0     <= '0;
                        xr1     <= '0;
                        g       <= '0;
                        g2      <= '0;
                        t       <= '0;
                        a       <= '0;
                        a0_o    <= '0;
                        a1_o    <= '0;
                        valid_o <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_abr_masked_b2a_conv.sv
// Directed bench for the masked B2A converter, WIDTH = 8.
// Checks reset, results, latency, mask independence, wrap, backpressure, clears.
// Drives inputs 1ns after the rising edge and samples outputs at the same point.
module tb_abr_masked_b2a_conv;

    logic       clk = 1'b0;
    logic       rst;
    logic       zeroize;
    logic       valid_i;
    logic       ready_o;
    logic [1:0] x_i [7:0];
    logic [7:0] rnd_i;
    logic       valid_o;
    logic       ready_i;
    logic [7:0] a0_o;
    logic [7:0] a1_o;

    int n_vec = 0;
    int n_err = 0;

    abr_masked_b2a_conv #(.WIDTH(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .zeroize (zeroize),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .x_i     (x_i),
        .rnd_i   (rnd_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .a0_o    (a0_o),
        .a1_o    (a1_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_x(input logic [7:0] x0, input logic [7:0] x1);
        for (int i = 0; i < 8; i++) x_i[i] = {x1[i], x0[i]};
    endtask

    // Accept one request, then wait (bounded) for valid_o and check the result.
    task automatic run_conv(input logic [7:0] x0, input logic [7:0] x1,
                            input logic [7:0] gm, input logic [7:0] exp_a0,
                            input string tag);
        int n;
        set_x(x0, x1);
        rnd_i   = gm;
        valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        chk({tag, "_busy"}, {31'd0, ready_o}, 32'd0);
        n = 0;
        while (!valid_o && n < 12) begin
            tick();
            n++;
        end
        chk({tag, "_lat"}, n, 32'd4);
        chk({tag, "_a0"}, {24'd0, a0_o}, {24'd0, exp_a0});
        chk({tag, "_a1"}, {24'd0, a1_o}, {24'd0, x1});
        chk({tag, "_sum"}, {24'd0, 8'(a0_o + a1_o)}, {24'd0, x0 ^ x1});
    endtask

    initial begin
        logic [7:0] hold_a0;
        logic [7:0] rx0, rx1, rg;
        rst = 1'b1; zeroize = 1'b0; valid_i = 1'b0; ready_i = 1'b1; rnd_i = '0;
        set_x(8'h00, 8'h00);
        tick(); tick();
        rst = 1'b0;

        // Reset state
        chk("rst_ready", {31'd0, ready_o}, 32'd1);
        chk("rst_valid", {31'd0, valid_o}, 32'd0);
        chk("rst_a0", {24'd0, a0_o}, 32'd0);
        chk("rst_a1", {24'd0, a1_o}, 32'd0);

        // Basic conversion, G=0: (0x5A^0x3C)-0x3C = 0x66-0x3C = 0x2A
        run_conv(8'h5A, 8'h3C, 8'h00, 8'h2A, "g00");
        tick();
        chk("g00_pulse", {31'd0, valid_o}, 32'd0);
        chk("g00_clr_a0", {24'd0, a0_o}, 32'd0);
        chk("g00_rdy", {31'd0, ready_o}, 32'd1);

        // Same x with G=0xFF; t after ST3 = ((0x5A^0xFF)-0xFF)^0x5A = 0xFC
        set_x(8'h5A, 8'h3C);
        rnd_i = 8'hFF; valid_i = 1'b1;
        tick();                        // accepted, now ST1
        valid_i = 1'b0;
        tick(); tick(); tick();        // ST1, ST2, ST3 done: in ST4
        chk("gff_t_st3", {24'd0, dut.t}, 32'h0000_00FC);
        tick();
        chk("gff_valid", {31'd0, valid_o}, 32'd1);
        chk("gff_a0", {24'd0, a0_o}, 32'h2A);
        chk("gff_a1", {24'd0, a1_o}, 32'h3C);
        tick();

        // Wrap: x0=0x00, x1=0xFF -> x=0xFF, A = 0xFF-0xFF = 0x00
        run_conv(8'h00, 8'hFF, 8'h81, 8'h00, "wrap");
        tick();

        // Backpressure: hold result for 10 cycles, new requests ignored
        ready_i = 1'b0;
        run_conv(8'hC3, 8'h11, 8'h5E, 8'hC1, "bp");   // 0xD2-0x11 = 0xC1
        hold_a0 = a0_o;
        set_x(8'hAA, 8'h55); rnd_i = 8'h77; valid_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_hold_v", {31'd0, valid_o}, 32'd1);
            chk("bp_hold_a0", {24'd0, a0_o}, {24'd0, hold_a0});
            chk("bp_hold_a1", {24'd0, a1_o}, 32'h11);
            chk("bp_hold_rdy", {31'd0, ready_o}, 32'd0);
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        tick();
        chk("bp_rel_v", {31'd0, valid_o}, 32'd0);
        chk("bp_rel_a0", {24'd0, a0_o}, 32'd0);
        chk("bp_rel_a1", {24'd0, a1_o}, 32'd0);
        chk("bp_rel_rdy", {31'd0, ready_o}, 32'd1);

        // Zeroize while in ST2
        set_x(8'h12, 8'h34); rnd_i = 8'h9C; valid_i = 1'b1;
        tick();                        // ST1
        valid_i = 1'b0;
        tick();                        // ST2
        zeroize = 1'b1;
        tick();
        zeroize = 1'b0;
        chk("zer_v", {31'd0, valid_o}, 32'd0);
        chk("zer_rdy", {31'd0, ready_o}, 32'd1);
        chk("zer_a0", {24'd0, a0_o}, 32'd0);
        chk("zer_t", {24'd0, dut.t}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("zer_novalid", {31'd0, valid_o}, 32'd0);
        end

        // rst while in DONE
        ready_i = 1'b0;
        run_conv(8'hF0, 8'h0F, 8'h3A, 8'hF0, "rstd"); // 0xFF-0x0F = 0xF0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ready_i = 1'b1;
        chk("rstd_v", {31'd0, valid_o}, 32'd0);
        chk("rstd_a0", {24'd0, a0_o}, 32'd0);
        chk("rstd_a1", {24'd0, a1_o}, 32'd0);
        chk("rstd_rdy", {31'd0, ready_o}, 32'd1);

        // Conversion after clears: 0x01^0x80 = 0x81, minus 0x80 = 0x01
        run_conv(8'h01, 8'h80, 8'h6D, 8'h01, "post");
        tick();

        // Short randomized run with stalls; model is (x0^x1)-x1
        for (int k = 0; k < 40; k++) begin
            rx0 = 8'($urandom);
            rx1 = 8'($urandom);
            rg  = 8'($urandom);
            ready_i = 1'b0;
            run_conv(rx0, rx1, rg, 8'((rx0 ^ rx1) - rx1), "rnd");
            repeat ($urandom_range(0, 3)) tick();
            chk("rnd_stall_v", {31'd0, valid_o}, 32'd1);
            ready_i = 1'b1;
            tick();
            chk("rnd_rdy", {31'd0, ready_o}, 32'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
